dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_LEN, default 25, meaning word-address width.
REQ-002 The module SHALL have parameter INDEX_LEN, default 10, meaning index width (2^INDEX_LEN lines, one 32-bit word per line); TAG_LEN = ADDR_LEN-INDEX_LEN.
REQ-003 The module SHALL have port clk  in  1  the single clock; all state SHALL update on posedge clk.
REQ-004 The module SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port req_valid  in  1  CPU memory access valid; held stable by the CPU while stall=1.
REQ-006 The module SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 The module SHALL have port req_addr  in  ADDR_LEN  word address; 0 is the UART MMIO address.
REQ-008 The module SHALL have port req_wdata  in  32  store data.
REQ-009 The module SHALL have port stall  out  1  pipeline stall (combinational).
REQ-010 The module SHALL have port rdata  out  32  load data (registered).
REQ-011 The module SHALL have port rdata_valid  out  1  rdata valid (registered, one-cycle pulse).
REQ-012 The module SHALL have ports mem_req, mem_we (out 1), mem_addr (out ADDR_LEN) and mem_wdata (out 32) forming the DRAM request.
REQ-013 The module SHALL have ports mem_ack  in  1  one-cycle completion, and mem_rdata  in  32  read data, valid when mem_ack=1.

Function
REQ-014 Arrays SHALL be direct-mapped: data[32], tag[TAG_LEN] and valid[1] per line, with asynchronous read and synchronous write, and {tag,index} = req_addr.
REQ-015 The FSM SHALL have states IDLE, MISS, WRITE and RESP.
REQ-016 A request with req_addr==0 SHALL be ignored: stall=0, no mem_req, no array write, no rdata_valid.
REQ-017 In IDLE, a load hit (valid & tag match) SHALL give stall=0, and at the next edge rdata<=data[index] and rdata_valid<=1 (latency 1).
REQ-018 In IDLE, a load miss SHALL give stall=1 that cycle and SHALL cause the transition to MISS.
REQ-019 In IDLE, any store SHALL give stall=1 that cycle and SHALL cause the transition to WRITE (write-through, every store goes to DRAM).
REQ-020 In MISS, mem_req=1, mem_we=0, mem_addr=req_addr and stall=1 SHALL hold; on mem_ack, data/tag SHALL be written from mem_rdata, valid SHALL be set, and the state SHALL move to RESP.
REQ-021 In WRITE, mem_req=1, mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata and stall=1 SHALL hold; on mem_ack, if the line hits, data SHALL be updated to req_wdata (no allocate on a store miss), and the state SHALL move to RESP.
REQ-022 In RESP, stall=0 SHALL hold and the held request SHALL complete; for a load, rdata<=data[index] and rdata_valid<=1 at the edge; RESP SHALL go to IDLE unconditionally.
REQ-023 mem_req SHALL stay asserted with stable address and data until the cycle of mem_ack, inclusive, and SHALL be 0 in IDLE and RESP.
REQ-024 mem_ack outside MISS/WRITE SHALL be ignored.
REQ-025 Outside REQ-017 and REQ-022, rdata_valid SHALL be 0 and rdata SHALL hold its last value.
REQ-026 Each load SHALL issue at most one mem_req transaction, and each store exactly one.

Reset
REQ-027 On rst=0, the state SHALL become IDLE and all valid bits SHALL clear, immediately and regardless of the state.
REQ-028 On rst=0, rdata=0, rdata_valid=0 and mem_req=0; stall SHALL be 0 unless IDLE logic asserts it.
REQ-029 A transaction in flight at reset SHALL be abandoned, and a late mem_ack after reset SHALL be ignored.
REQ-030 Tag and data arrays SHALL not require reset.

Structure
REQ-031 ADDR_LEN, INDEX_LEN, derived TAG_LEN and the state enum type SHALL live in package dcache_pkg.
REQ-032 The arrays SHALL be one sub-module, dcache_array (async read, sync write, per-line valid flop vector with async clear).

Verification
REQ-033 The bench SHALL cover: load addr 0x10 after reset -> stall=1, MISS, mem_req addr 0x10; mem_ack with rdata 0xDEADBEEF after 3 cycles -> RESP, rdata=0xDEADBEEF, rdata_valid pulse; repeat load -> hit, no mem_req, 1-cycle latency.
REQ-034 The bench SHALL cover: store 0x12345678 to 0x10 (cached) -> WRITE, mem_we=1; after ack, load 0x10 -> hit returns 0x12345678.
REQ-035 The bench SHALL cover: store to uncached 0x20 -> one DRAM write, then load 0x20 -> miss (no allocate).
REQ-036 The bench SHALL cover: alias 0x10 and 0x10+2^INDEX_LEN -> second load misses and evicts; reload 0x10 -> miss again.
REQ-037 The bench SHALL cover: load/store addr 0 -> stall=0, mem_req=0, rdata_valid=0.
REQ-038 The bench SHALL cover: rst=0 during MISS -> mem_req drops immediately, IDLE; a late mem_ack is ignored; prior hit address 0x10 now misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the direct-mapped, write-through data cache
// controller: default geometry (word-address width, index width, derived
// tag width) and the controller state type.
package dcache_pkg;

  localparam int ADDR_LEN  = 25;
  localparam int INDEX_LEN = 10;
  localparam int TAG_LEN   = ADDR_LEN - INDEX_LEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if
// DRAM request/acknowledge bus between the cache controller and memory.
//   mem_req   : request active, held until (and including) the ack cycle
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address of the access
//   mem_wdata : store data for writes
//   mem_ack   : one-cycle completion pulse from memory
//   mem_rdata : read data, valid while mem_ack = 1
// Modports: master = cache controller, slave = memory.
interface dcache_ctrl_if #(
  parameter int ADDR_LEN = dcache_pkg::ADDR_LEN
) ();

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic                mem_ack;
  logic [31:0]         mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array
// Direct-mapped storage: one 32-bit data word, a tag and a valid bit per line.
// Data and tag are read asynchronously at 'index' and written on the clock
// edge; they carry no reset. The valid bits are a flop vector cleared
// asynchronously by rst (active-low).
//   clk, rst    : clock, asynchronous active-low reset
//   index       : line selected for both read and write
//   rd_data/rd_tag/rd_valid : contents of the selected line
//   data_we, data_wdata     : overwrite the data word of the selected line
//   fill_en, fill_tag       : install a tag and mark the selected line valid
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_LEN = dcache_pkg::INDEX_LEN,
  parameter int TAG_LEN   = dcache_pkg::TAG_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_LEN-1:0] index,
  output logic [31:0]          rd_data,
  output logic [TAG_LEN-1:0]   rd_tag,
  output logic                 rd_valid,
  input  logic                 data_we,
  input  logic [31:0]          data_wdata,
  input  logic                 fill_en,
  input  logic [TAG_LEN-1:0]   fill_tag
);

  localparam int LINES = 1 << INDEX_LEN;

  logic [31:0]        data_mem [LINES];
  logic [TAG_LEN-1:0] tag_mem  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   valid_d;

  assign rd_data  = data_mem[index];
  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_q[index];

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[index] <= data_wdata;
    end
    if (fill_en) begin
      tag_mem[index] <= fill_tag;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one 32-bit word per line. Loads that hit return data one cycle later; load
// misses fetch the word from DRAM and fill the line; every store is written
// to DRAM and updates the cached copy only if the line already hits.
// Word address 0 is the UART MMIO location and is never cached or forwarded.
//   clk, rst                : clock, asynchronous active-low reset
//   req_valid/req_we/req_addr/req_wdata : CPU request, held while stall = 1
//   stall                   : combinational pipeline stall
//   rdata, rdata_valid      : registered load result and one-cycle strobe
//   mem                     : DRAM request bus (master side)
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_LEN  = dcache_pkg::ADDR_LEN,
  parameter int INDEX_LEN = dcache_pkg::INDEX_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [31:0]         req_wdata,
  output logic                stall,
  output logic [31:0]         rdata,
  output logic                rdata_valid,
  dcache_ctrl_if.master       mem
);

  localparam int TAG_LEN = ADDR_LEN - INDEX_LEN;

  state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic [INDEX_LEN-1:0] index;
  logic [TAG_LEN-1:0]   tag;
  logic [31:0]          line_data;
  logic [TAG_LEN-1:0]   line_tag;
  logic                 line_valid;
  logic                 hit;
  logic                 active;

  logic        data_we;
  logic [31:0] data_wdata;
  logic        fill_en;

  assign index  = req_addr[INDEX_LEN-1:0];
  assign tag    = req_addr[ADDR_LEN-1:INDEX_LEN];
  assign hit    = line_valid && (line_tag == tag);
  // Address 0 is MMIO: such requests bypass the cache entirely.
  assign active = req_valid && (req_addr != '0);

  dcache_array #(
    .INDEX_LEN (INDEX_LEN),
    .TAG_LEN   (TAG_LEN)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .rd_data    (line_data),
    .rd_tag     (line_tag),
    .rd_valid   (line_valid),
    .data_we    (data_we),
    .data_wdata (data_wdata),
    .fill_en    (fill_en),
    .fill_tag   (tag)
  );

  // Address and store data come straight from the held CPU request, so they
  // stay stable for the whole DRAM transaction; only mem_req/mem_we qualify.
  assign mem.mem_addr  = req_addr;
  assign mem.mem_wdata = req_wdata;

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    stall         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    data_we       = 1'b0;
    data_wdata    = mem.mem_rdata;
    fill_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (active) begin
          if (req_we) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            rdata_d       = line_data;
            rdata_valid_d = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = MISS;
          end
        end
      end

      MISS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          data_we = 1'b1;
          fill_en = 1'b1;
          state_d = RESP;
        end
      end

      WRITE: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ack) begin
          // No write-allocate: only refresh a line that already holds this address.
          data_we    = hit;
          data_wdata = req_wdata;
          state_d    = RESP;
        end
      end

      RESP: begin
        // The line was filled on the previous edge, so the async read now
        // returns the fetched word for a load.
        if (!req_we) begin
          rdata_d       = line_data;
          rdata_valid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
